// File: rtl/cve2_pkg.sv
// Shared types for the cve2 core slice: interrupt bundle, CLINT register map and helpers.
package cve2_pkg;

  typedef struct packed {
    logic        irq_software;
    logic        irq_timer;
    logic        irq_external;
    logic [14:0] irq_fast;
  } irqs_t;

  localparam logic [7:0] CLINT_OFF_MSIP      = 8'h00;
  localparam logic [7:0] CLINT_OFF_FIRQ_PEND = 8'h04;
  localparam logic [7:0] CLINT_OFF_FIRQ_EN   = 8'h08;
  localparam logic [7:0] CLINT_OFF_MTIME     = 8'h10;
  localparam logic [7:0] CLINT_OFF_MTIMECMP  = 8'h18;

  typedef enum logic [2:0] {
    CLINT_REG_NONE,
    CLINT_REG_MSIP,
    CLINT_REG_FIRQ_PEND,
    CLINT_REG_FIRQ_EN,
    CLINT_REG_MTIME_LO,
    CLINT_REG_MTIME_HI,
    CLINT_REG_CMP_LO,
    CLINT_REG_CMP_HI
  } clint_reg_e;

  function automatic clint_reg_e clint_decode(input logic [7:0] addr);
    clint_reg_e sel;
    sel = CLINT_REG_NONE;
    if (addr[1:0] == 2'b00) begin
      case (addr)
        CLINT_OFF_MSIP:               sel = CLINT_REG_MSIP;
        CLINT_OFF_FIRQ_PEND:          sel = CLINT_REG_FIRQ_PEND;
        CLINT_OFF_FIRQ_EN:            sel = CLINT_REG_FIRQ_EN;
        CLINT_OFF_MTIME:              sel = CLINT_REG_MTIME_LO;
        CLINT_OFF_MTIME + 8'h04:      sel = CLINT_REG_MTIME_HI;
        CLINT_OFF_MTIMECMP:           sel = CLINT_REG_CMP_LO;
        CLINT_OFF_MTIMECMP + 8'h04:   sel = CLINT_REG_CMP_HI;
        default:                      sel = CLINT_REG_NONE;
      endcase
    end
    return sel;
  endfunction

  function automatic logic [31:0] clint_be_merge(input logic [31:0] old_val,
                                                 input logic [31:0] new_val,
                                                 input logic [3:0]  be);
    logic [31:0] res;
    res = old_val;
    for (int unsigned i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/cve2_clint_timer.sv
// 64-bit MTIME counter with tick increment, byte-lane bus writes and MTIMECMP compare.
module cve2_clint_timer
  import cve2_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        tick_i,
  input  logic        mtime_lo_we_i,
  input  logic        mtime_hi_we_i,
  input  logic        cmp_lo_we_i,
  input  logic        cmp_hi_we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] wdata_i,
  output logic [63:0] mtime_o,
  output logic [63:0] mtimecmp_o,
  output logic        timer_hit_o
);

  logic [31:0] lo_q, hi_q, cmp_lo_q, cmp_hi_q;
  logic [31:0] lo_d, hi_d;
  logic        carry;

  // A written half takes the bus value; a written low half also suppresses the carry.
  always_comb begin
    lo_d  = lo_q;
    hi_d  = hi_q;
    carry = 1'b0;
    if (tick_i) begin
      {carry, lo_d} = {1'b0, lo_q} + 33'd1;
      hi_d          = hi_q + {31'd0, carry};
    end
    if (mtime_lo_we_i) begin
      lo_d = clint_be_merge(lo_q, wdata_i, be_i);
      hi_d = hi_q;
    end
    if (mtime_hi_we_i) begin
      hi_d = clint_be_merge(hi_q, wdata_i, be_i);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lo_q     <= '0;
      hi_q     <= '0;
      cmp_lo_q <= '1;
      cmp_hi_q <= '1;
    end else begin
      lo_q <= lo_d;
      hi_q <= hi_d;
      if (cmp_lo_we_i) cmp_lo_q <= clint_be_merge(cmp_lo_q, wdata_i, be_i);
      if (cmp_hi_we_i) cmp_hi_q <= clint_be_merge(cmp_hi_q, wdata_i, be_i);
    end
  end

  assign mtime_o     = {hi_q, lo_q};
  assign mtimecmp_o  = {cmp_hi_q, cmp_lo_q};
  assign timer_hit_o = (mtime_o >= mtimecmp_o);

endmodule

// File: rtl/cve2_clint_lite.sv
// Lightweight CLINT: MSIP, MTIME/MTIMECMP timer and optional fast-interrupt pending/enable
// registers (built only when CVE2_CLINT_FAST_IRQ_EN is defined).
module cve2_clint_lite
  import cve2_pkg::*;
#(
  parameter bit FastIrqSync = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [7:0]  addr_i,
  input  logic [31:0] wdata_i,
  output logic        gnt_o,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  input  logic        tick_i,
  input  logic        irq_external_i,
  input  logic [14:0] irq_fast_i,
  output irqs_t       irqs_o
);

  clint_reg_e  reg_sel;
  logic        acc_err;
  logic        bus_we;
  logic [31:0] rd_val;
  logic        msip_q;
  logic [63:0] mtime;
  logic [63:0] mtimecmp;
  logic        timer_hit;
  logic [14:0] firq_pend;
  logic [14:0] firq_en;
  logic        rvalid_q;
  logic        err_q;
  logic [31:0] rdata_q;
  irqs_t       irqs_q;

  assign gnt_o   = req_i;
  assign reg_sel = clint_decode(addr_i);
  assign acc_err = (reg_sel == CLINT_REG_NONE);
  assign bus_we  = req_i & we_i & ~acc_err;

  cve2_clint_timer u_timer (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .tick_i        (tick_i),
    .mtime_lo_we_i (bus_we && (reg_sel == CLINT_REG_MTIME_LO)),
    .mtime_hi_we_i (bus_we && (reg_sel == CLINT_REG_MTIME_HI)),
    .cmp_lo_we_i   (bus_we && (reg_sel == CLINT_REG_CMP_LO)),
    .cmp_hi_we_i   (bus_we && (reg_sel == CLINT_REG_CMP_HI)),
    .be_i          (be_i),
    .wdata_i       (wdata_i),
    .mtime_o       (mtime),
    .mtimecmp_o    (mtimecmp),
    .timer_hit_o   (timer_hit)
  );

`ifdef CVE2_CLINT_FAST_IRQ_EN
  logic [14:0] sync1_q, sync2_q, prev_q;
  logic [14:0] pend_q, en_q, pend_d, en_d;
  logic [14:0] fast_src, fast_rise;
  logic [31:0] wmask, en_wr;

  assign fast_src  = FastIrqSync ? sync2_q : irq_fast_i;
  assign fast_rise = fast_src & ~prev_q;

  // New edges are OR-ed in after the W1C clear so a coincident set wins.
  always_comb begin
    wmask  = clint_be_merge('0, wdata_i, be_i);
    en_wr  = clint_be_merge({17'd0, en_q}, wdata_i, be_i);
    pend_d = pend_q;
    en_d   = en_q;
    if (bus_we && (reg_sel == CLINT_REG_FIRQ_PEND)) pend_d = pend_q & ~wmask[14:0];
    if (bus_we && (reg_sel == CLINT_REG_FIRQ_EN))   en_d   = en_wr[14:0];
    pend_d = pend_d | fast_rise;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      pend_q  <= '0;
      en_q    <= '0;
    end else begin
      sync1_q <= irq_fast_i;
      sync2_q <= sync1_q;
      prev_q  <= fast_src;
      pend_q  <= pend_d;
      en_q    <= en_d;
    end
  end

  assign firq_pend = pend_q;
  assign firq_en   = en_q;
`else
  logic unused_fast;
  assign unused_fast = ^{irq_fast_i, FastIrqSync};
  assign firq_pend   = '0;
  assign firq_en     = '0;
`endif

  always_comb begin
    rd_val = '0;
    case (reg_sel)
      CLINT_REG_MSIP:      rd_val = {31'd0, msip_q};
      CLINT_REG_FIRQ_PEND: rd_val = {17'd0, firq_pend};
      CLINT_REG_FIRQ_EN:   rd_val = {17'd0, firq_en};
      CLINT_REG_MTIME_LO:  rd_val = mtime[31:0];
      CLINT_REG_MTIME_HI:  rd_val = mtime[63:32];
      CLINT_REG_CMP_LO:    rd_val = mtimecmp[31:0];
      CLINT_REG_CMP_HI:    rd_val = mtimecmp[63:32];
      default:             rd_val = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      msip_q   <= 1'b0;
      irqs_q   <= '0;
    end else begin
      rvalid_q <= req_i;
      err_q    <= req_i & acc_err;
      rdata_q  <= (req_i && !we_i && !acc_err) ? rd_val : '0;
      if (bus_we && (reg_sel == CLINT_REG_MSIP) && be_i[0]) msip_q <= wdata_i[0];
      irqs_q.irq_software <= msip_q;
      irqs_q.irq_timer    <= timer_hit;
      irqs_q.irq_external <= irq_external_i;
      irqs_q.irq_fast     <= firq_pend & firq_en;
    end
  end

  assign rvalid_o = rvalid_q;
  assign err_o    = err_q;
  assign rdata_o  = rdata_q;
  assign irqs_o   = irqs_q;

endmodule

// File: tb/tb_cve2_clint_lite.sv
// Directed bench for cve2_clint_lite; bus responses are checked against a scoreboard queue.
module tb_cve2_clint_lite;
  import cve2_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req, we;
  logic [3:0]  be;
  logic [7:0]  addr;
  logic [31:0] wdata;
  logic        gnt, rvalid, err;
  logic [31:0] rdata;
  logic        tick, irq_ext;
  logic [14:0] irq_fast;
  irqs_t       irqs;
  irqs_t       exp_irqs;

  typedef struct {
    string       tag;
    logic [31:0] rdata;
    logic        err;
    bit          chk_rdata;
  } exp_t;

  exp_t        sb[$];
  int unsigned errors = 0;
  int unsigned checks = 0;

  cve2_clint_lite #(.FastIrqSync(1'b1)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .req_i          (req),
    .we_i           (we),
    .be_i           (be),
    .addr_i         (addr),
    .wdata_i        (wdata),
    .gnt_o          (gnt),
    .rvalid_o       (rvalid),
    .rdata_o        (rdata),
    .err_o          (err),
    .tick_i         (tick),
    .irq_external_i (irq_ext),
    .irq_fast_i     (irq_fast),
    .irqs_o         (irqs)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus(input string tag, input logic w, input logic [3:0] b, input logic [7:0] a,
                     input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err);
    exp_t e;
    e.tag       = tag;
    e.rdata     = exp_rd;
    e.err       = exp_err;
    e.chk_rdata = !w || exp_err;
    sb.push_back(e);
    req = 1'b1; we = w; be = b; addr = a; wdata = wd;
    #1;
    chk({tag, "/gnt"}, {63'd0, gnt}, 64'd1);
    @(posedge clk);
    #1;
    req = 1'b0; we = 1'b0; be = '0; wdata = '0;
    chk({tag, "/rvalid"}, {63'd0, rvalid}, 64'd1);
    e = sb.pop_front();
    if (e.chk_rdata) chk({e.tag, "/rdata"}, {32'd0, rdata}, {32'd0, e.rdata});
    chk({e.tag, "/err"}, {63'd0, err}, {63'd0, e.err});
  endtask

  task automatic rd(input string tag, input logic [7:0] a, input logic [31:0] exp_rd);
    bus(tag, 1'b0, 4'hF, a, 32'd0, exp_rd, 1'b0);
  endtask

  task automatic wr(input string tag, input logic [7:0] a, input logic [31:0] wd);
    bus(tag, 1'b1, 4'hF, a, wd, 32'd0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; req = 1'b0; we = 1'b0; be = '0; addr = '0; wdata = '0;
    tick = 1'b0; irq_ext = 1'b0; irq_fast = '0;
    step(2);
    chk("rst/rvalid", {63'd0, rvalid}, 64'd0);
    chk("rst/irqs", {46'd0, irqs}, 64'd0);
    rst_n = 1'b1;
    step(1);
    chk("rel/rvalid", {63'd0, rvalid}, 64'd0);
    chk("rel/err", {63'd0, err}, 64'd0);
    rd("rst/cmp_lo", 8'h18, 32'hFFFF_FFFF);
    rd("rst/cmp_hi", 8'h1C, 32'hFFFF_FFFF);
    rd("rst/mtime_lo", 8'h10, 32'd0);

    // Timer compare: irq_timer registered one cycle after MTIME reaches 5.
    wr("cmp_lo=5", 8'h18, 32'd5);
    wr("cmp_hi=0", 8'h1C, 32'd0);
    chk("timer/idle", {63'd0, irqs.irq_timer}, 64'd0);
    tick = 1'b1;
    for (int unsigned n = 1; n <= 7; n++) begin
      step(1);
      chk($sformatf("timer/n%0d", n), {63'd0, irqs.irq_timer}, {63'd0, (n - 1) >= 5});
    end
    tick = 1'b0;
    rd("mtime_after7", 8'h10, 32'd7);

    // Carry, write-over-tick priority and 64-bit wrap.
    wr("mtime_lo=ff", 8'h10, 32'hFFFF_FFFF);
    wr("mtime_hi=0", 8'h14, 32'd0);
    tick = 1'b1; step(1); tick = 1'b0;
    rd("carry/hi", 8'h14, 32'd1);
    rd("carry/lo", 8'h10, 32'd0);
    tick = 1'b1; wr("lo_wr_tick", 8'h10, 32'h10); tick = 1'b0;
    rd("lo_wr_tick/lo", 8'h10, 32'h10);
    rd("lo_wr_tick/hi", 8'h14, 32'd1);
    tick = 1'b1; wr("hi_wr_tick", 8'h14, 32'h22); tick = 1'b0;
    rd("hi_wr_tick/lo", 8'h10, 32'h11);
    rd("hi_wr_tick/hi", 8'h14, 32'h22);
    wr("wrap_lo", 8'h10, 32'hFFFF_FFFF);
    wr("wrap_hi", 8'h14, 32'hFFFF_FFFF);
    tick = 1'b1; step(1); tick = 1'b0;
    rd("wrap/lo", 8'h10, 32'd0);
    rd("wrap/hi", 8'h14, 32'd0);
    chk("wrap/irq_timer", {63'd0, irqs.irq_timer}, 64'd0);

    // Byte-lane writes on MTIMECMP.
    bus("cmp_lo_be0", 1'b1, 4'b0001, 8'h18, 32'hAABB_CCDD, 32'd0, 1'b0);
    rd("cmp_lo_be0/rd", 8'h18, 32'h0000_00DD);
    bus("cmp_hi_be3", 1'b1, 4'b1000, 8'h1C, 32'h1234_5678, 32'd0, 1'b0);
    rd("cmp_hi_be3/rd", 8'h1C, 32'h1200_0000);

    // Software and external interrupts.
    wr("msip=1", 8'h00, 32'd1);
    chk("msip/lat0", {63'd0, irqs.irq_software}, 64'd0);
    step(1);
    chk("msip/lat1", {63'd0, irqs.irq_software}, 64'd1);
    rd("msip/rd1", 8'h00, 32'd1);
    wr("msip=0", 8'h00, 32'd0);
    step(1);
    chk("msip/clr", {63'd0, irqs.irq_software}, 64'd0);
    bus("msip_be0", 1'b1, 4'b0000, 8'h00, 32'd1, 32'd0, 1'b0);
    rd("msip_be0/rd", 8'h00, 32'd0);
    irq_ext = 1'b1;
    #1;
    chk("ext/lat0", {63'd0, irqs.irq_external}, 64'd0);
    step(1);
    chk("ext/lat1", {63'd0, irqs.irq_external}, 64'd1);
    irq_ext = 1'b0;
    step(1);
    chk("ext/clr", {63'd0, irqs.irq_external}, 64'd0);

    // Error responses leave state untouched.
    bus("rd_0x40", 1'b0, 4'hF, 8'h40, 32'd0, 32'd0, 1'b1);
    bus("rd_0x0C", 1'b0, 4'hF, 8'h0C, 32'd0, 32'd0, 1'b1);
    bus("wr_0x02", 1'b1, 4'hF, 8'h02, 32'd1, 32'd0, 1'b1);
    rd("wr_0x02/msip", 8'h00, 32'd0);
    bus("wr_0x12", 1'b1, 4'hF, 8'h12, 32'h5555, 32'd0, 1'b1);
    rd("wr_0x12/mtime", 8'h10, 32'd0);
    step(1);
    chk("err/irq_sw", {63'd0, irqs.irq_software}, 64'd0);

`ifdef CVE2_CLINT_FAST_IRQ_EN
    wr("firq_en=4", 8'h08, 32'h0004);
    rd("firq_en/rd", 8'h08, 32'h0004);
    irq_fast[2] = 1'b1; step(1); irq_fast[2] = 1'b0;
    step(5);
    chk("firq/irq", {49'd0, irqs.irq_fast}, 64'h4);
    rd("firq/pend", 8'h04, 32'h0004);
    // Pulse so the synchronised rising edge lines up with the W1C write.
    irq_fast[2] = 1'b1; step(1); irq_fast[2] = 1'b0;
    step(1);
    wr("w1c_vs_edge", 8'h04, 32'h0004);
    rd("w1c_vs_edge/pend", 8'h04, 32'h0004);
    wr("w1c", 8'h04, 32'h0004);
    rd("w1c/pend", 8'h04, 32'd0);
    step(1);
    chk("w1c/irq", {49'd0, irqs.irq_fast}, 64'd0);
    irq_fast[5] = 1'b1; step(1); irq_fast[5] = 1'b0;
    step(5);
    rd("firq5/pend", 8'h04, 32'h0020);
    chk("firq5/masked", {49'd0, irqs.irq_fast}, 64'd0);
`else
    rd("nofirq/pend", 8'h04, 32'd0);
    wr("nofirq/en_wr", 8'h08, 32'h7FFF);
    rd("nofirq/en", 8'h08, 32'd0);
    irq_fast = '1; step(1); irq_fast = '0;
    step(5);
    chk("nofirq/irq", {49'd0, irqs.irq_fast}, 64'd0);
`endif

    // Reset asserted while an access is in flight.
    wr("pre_rst/msip", 8'h00, 32'd1);
    irq_ext = 1'b1;
    step(2);
    exp_irqs = '0;
    exp_irqs.irq_software = 1'b1;
    exp_irqs.irq_external = 1'b1;
    chk("pre_rst/irqs", {46'd0, irqs}, {46'd0, exp_irqs});
    req = 1'b1; we = 1'b0; be = 4'hF; addr = 8'h00;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst/rvalid", {63'd0, rvalid}, 64'd0);
    chk("mid_rst/err", {63'd0, err}, 64'd0);
    chk("mid_rst/rdata", {32'd0, rdata}, 64'd0);
    chk("mid_rst/irqs", {46'd0, irqs}, 64'd0);
    step(2);
    req = 1'b0; irq_ext = 1'b0;
    rst_n = 1'b1;
    step(1);
    chk("post_rst/rvalid0", {63'd0, rvalid}, 64'd0);
    step(1);
    chk("post_rst/rvalid1", {63'd0, rvalid}, 64'd0);
    chk("post_rst/irqs", {46'd0, irqs}, 64'd0);
    rd("post_rst/cmp_lo", 8'h18, 32'hFFFF_FFFF);
    rd("post_rst/cmp_hi", 8'h1C, 32'hFFFF_FFFF);
    rd("post_rst/msip", 8'h00, 32'd0);
    rd("post_rst/mtime_hi", 8'h14, 32'd0);
    chk("sb_empty", {32'd0, sb.size()}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not reach its end");
    $fatal(1, "timeout");
  end

endmodule
